// File: rtl/sipo_shift_reg_if.sv
// sipo_shift_reg_if: serial input and parallel output bundle for sipo_shift_reg.
// master drives the serial side (d, en) and slave (the assembler) drives the
// parallel result (Qp, valid, bitcnt, parity). Clock and reset are not part of
// the bundle; they stay plain ports on the design.
interface sipo_shift_reg_if #(
  parameter int WIDTH = 4
) ();

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic             d;
  logic             en;
  logic [WIDTH-1:0] Qp;
  logic             valid;
  logic [CNT_W-1:0] bitcnt;
  logic             parity;

  modport master (
    output d,
    output en,
    input  Qp,
    input  valid,
    input  bitcnt,
    input  parity
  );

  modport slave (
    input  d,
    input  en,
    output Qp,
    output valid,
    output bitcnt,
    output parity
  );

endinterface

// File: rtl/sipo_shift_reg.sv
// sipo_shift_reg: serial-in, parallel-out word assembler.
// Captures one serial bit per rising edge of c where en=1, MSB first, and
// publishes every WIDTH bits as a parallel word on Qp with a one-cycle valid
// strobe. All outputs are registered; reset is synchronous and active high.
// Optional feature macro: SIPO_PARITY_EN adds a registered XOR of Qp on
// parity; without it parity is tied to 0.
module sipo_shift_reg #(
  parameter int WIDTH = 4
) (
  input logic             c,
  input logic             rst,
  sipo_shift_reg_if.slave bus
);

  localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  // Storage starts at zero so that simulation is deterministic before reset.
  logic [WIDTH-1:0] r_shiftReg = '0;
  logic [CNT_W-1:0] r_bitCnt   = '0;
  logic [WIDTH-1:0] r_word     = '0;
  logic             r_valid    = 1'b0;

  logic [WIDTH-1:0] w_nextWord;
  logic             w_wordDone;

  // The incoming bit enters at the LSB, so the oldest bit ends up in the MSB.
  assign w_nextWord = {r_shiftReg[WIDTH-2:0], bus.d};

  // A word completes on an enabled edge that brings in the last bit.
  assign w_wordDone = bus.en && (r_bitCnt == LAST_CNT);

  // Shift register: clear on reset, shift on enabled edges, hold otherwise.
  always_ff @(posedge c) begin
    if (rst) begin
      r_shiftReg <= '0;
    end else if (bus.en) begin
      r_shiftReg <= w_nextWord;
    end
  end

  // Bit counter: counts captured bits of the partial word and wraps on completion.
  always_ff @(posedge c) begin
    if (rst) begin
      r_bitCnt <= '0;
    end else if (bus.en) begin
      if (r_bitCnt == LAST_CNT) begin
        r_bitCnt <= '0;
      end else begin
        r_bitCnt <= r_bitCnt + 1'b1;
      end
    end
  end

  // Output word: loaded from the completed shift contents, held between completions.
  always_ff @(posedge c) begin
    if (rst) begin
      r_word <= '0;
    end else if (w_wordDone) begin
      r_word <= w_nextWord;
    end
  end

  // Valid strobe: high only for the cycle following a completing edge.
  always_ff @(posedge c) begin
    if (rst) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_wordDone;
    end
  end

`ifdef SIPO_PARITY_EN
  logic r_parity = 1'b0;

  // Parity: XOR of the new word, loaded together with the word and held with it.
  always_ff @(posedge c) begin
    if (rst) begin
      r_parity <= 1'b0;
    end else if (w_wordDone) begin
      r_parity <= ^w_nextWord;
    end
  end

  assign bus.parity = r_parity;
`else
  assign bus.parity = 1'b0;
`endif

  assign bus.Qp     = r_word;
  assign bus.valid  = r_valid;
  assign bus.bitcnt = r_bitCnt;

endmodule

// File: tb/tb_sipo_shift_reg.sv
// tb_sipo_shift_reg: directed vector table plus randomized run against a
// queue-based reference model of the word assembler (WIDTH=4).
module tb_sipo_shift_reg;

  localparam int W    = 4;
  localparam int CW   = $clog2(W);
`ifdef SIPO_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic c   = 1'b0;
  logic rst = 1'b0;

  sipo_shift_reg_if #(.WIDTH(W)) busIf ();

  sipo_shift_reg #(.WIDTH(W)) dut (
    .c   (c),
    .rst (rst),
    .bus (busIf)
  );

  always #5 c = ~c;

  typedef struct {
    logic          rst;
    logic          en;
    logic          d;
    logic [W-1:0]  qp;
    logic          v;
    logic [CW-1:0] cnt;
    logic          par;
  } vec_t;

  vec_t vecs[$];

  int total = 0;
  int bad   = 0;

  // Reference model: bits of the partial word in arrival order.
  bit            mBits[$];
  logic [W-1:0]  mQp    = '0;
  logic          mValid = 1'b0;
  logic          mPar   = 1'b0;

  task automatic checkVal(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [W-1:0] qp, input logic v,
                             input logic [CW-1:0] cnt, input logic par);
    checkVal({tag, ".Qp"},     busIf.Qp,     qp);
    checkVal({tag, ".valid"},  busIf.valid,  v);
    checkVal({tag, ".bitcnt"}, busIf.bitcnt, cnt);
    checkVal({tag, ".parity"}, busIf.parity, PAR_EN ? par : 1'b0);
  endtask

  task automatic modelStep(input logic r, input logic e, input logic b);
    logic [W-1:0] word;
    if (r) begin
      mBits.delete();
      mQp    = '0;
      mValid = 1'b0;
      mPar   = 1'b0;
    end else if (e) begin
      mBits.push_back(b);
      mValid = 1'b0;
      if (mBits.size() == W) begin
        word = '0;
        foreach (mBits[i]) word = {word[W-2:0], mBits[i]};
        mQp    = word;
        mValid = 1'b1;
        mPar   = ^word;
        mBits.delete();
      end
    end else begin
      mValid = 1'b0;
    end
  endtask

  // Drive inputs, take one rising edge, and return 1 time unit after it.
  task automatic applyStimulus(input logic r, input logic e, input logic b);
    rst      = r;
    busIf.en = e;
    busIf.d  = b;
    @(posedge c);
    #1;
    modelStep(r, e, b);
  endtask

  task automatic addVec(input logic r, input logic e, input logic b, input logic [W-1:0] qp,
                        input logic v, input logic [CW-1:0] cnt, input logic par);
    vec_t t;
    t.rst = r; t.en = e; t.d = b; t.qp = qp; t.v = v; t.cnt = cnt; t.par = par;
    vecs.push_back(t);
  endtask

  initial begin
    bit prevValid;
    bit savedD;
    bit savedEn;

    busIf.d  = 1'b0;
    busIf.en = 1'b0;

    // Reset with en=1, d=1
    addVec(1, 1, 1, 4'b0000, 0, 0, 0);
    // Single word 1,0,1,1
    addVec(0, 1, 1, 4'b0000, 0, 1, 0);
    addVec(0, 1, 0, 4'b0000, 0, 2, 0);
    addVec(0, 1, 1, 4'b0000, 0, 3, 0);
    addVec(0, 1, 1, 4'b1011, 1, 0, 1);
    // Gaps: 1, three disabled edges, then 0,0,1
    addVec(0, 1, 1, 4'b1011, 0, 1, 1);
    addVec(0, 0, 0, 4'b1011, 0, 1, 1);
    addVec(0, 0, 1, 4'b1011, 0, 1, 1);
    addVec(0, 0, 0, 4'b1011, 0, 1, 1);
    addVec(0, 1, 0, 4'b1011, 0, 2, 1);
    addVec(0, 1, 0, 4'b1011, 0, 3, 1);
    addVec(0, 1, 1, 4'b1001, 1, 0, 0);
    // Back-to-back 0,1,1,0 then 1,1,1,1
    addVec(0, 1, 0, 4'b1001, 0, 1, 0);
    addVec(0, 1, 1, 4'b1001, 0, 2, 0);
    addVec(0, 1, 1, 4'b1001, 0, 3, 0);
    addVec(0, 1, 0, 4'b0110, 1, 0, 0);
    addVec(0, 1, 1, 4'b0110, 0, 1, 0);
    addVec(0, 1, 1, 4'b0110, 0, 2, 0);
    addVec(0, 1, 1, 4'b0110, 0, 3, 0);
    addVec(0, 1, 1, 4'b1111, 1, 0, 0);
    // Reset mid-word: 1,1, reset, then 0,0,0,1
    addVec(0, 1, 1, 4'b1111, 0, 1, 0);
    addVec(0, 1, 1, 4'b1111, 0, 2, 0);
    addVec(1, 1, 1, 4'b0000, 0, 0, 0);
    addVec(0, 1, 0, 4'b0000, 0, 1, 0);
    addVec(0, 1, 0, 4'b0000, 0, 2, 0);
    addVec(0, 1, 0, 4'b0000, 0, 3, 0);
    addVec(0, 1, 1, 4'b0001, 1, 0, 1);

    // Pre-reset state is all zero
    #2;
    checkOutput("preReset", '0, 1'b0, '0, 1'b0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].d);
      checkOutput($sformatf("vec%0d", i), vecs[i].qp, vecs[i].v, vecs[i].cnt, vecs[i].par);
    end

    // Wrap: three full words with en held high
    applyStimulus(1, 0, 0);
    for (int i = 0; i < 3 * W; i++) begin
      applyStimulus(0, 1, 1'($urandom_range(0, 1)));
      checkOutput($sformatf("wrap%0d", i), mQp, mValid, CW'(mBits.size()), mPar);
      checkVal($sformatf("wrapRange%0d", i), (busIf.bitcnt <= CW'(W - 1)), 1);
    end

    // Randomized traffic with occasional reset
    prevValid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 1)));
      checkOutput($sformatf("rnd%0d", i), mQp, mValid, CW'(mBits.size()), mPar);
      checkVal($sformatf("rndNoDoubleValid%0d", i), (prevValid && busIf.valid), 0);
      prevValid = busIf.valid;
      // Toggling inputs while c is steady must not reach the outputs
      if (i % 50 == 7) begin
        savedD   = busIf.d;
        savedEn  = busIf.en;
        busIf.d  = ~busIf.d;
        busIf.en = ~busIf.en;
        #2;
        checkOutput($sformatf("midCycle%0d", i), mQp, mValid, CW'(mBits.size()), mPar);
        busIf.d  = savedD;
        busIf.en = savedEn;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sipo_shift_reg.md
Name: sipo_shift_reg

Overview:
- Serial-in, parallel-out word assembler placed directly downstream of a D flip-flop stage.
- Consumes the registered serial bit stream, one bit per enabled rising edge of c.
- Packs every WIDTH consecutive bits into a parallel word and raises a one-cycle valid strobe when a word completes.
- Built from edge-triggered storage, shifting on the same rising edge of c as the upstream flip-flop.

Parameters:
- WIDTH, default 4: number of serial bits per output word; legal range 2..16.

Ports:
- c  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset; sampled on the rising edge of c.
- d  input  1  serial data bit, normally the upstream flip-flop Q.
- en  input  1  shift enable; d is captured only on edges where en=1.
- Qp  output  WIDTH  last completed parallel word.
- valid  output  1  one-cycle strobe; high for exactly the cycle after the edge that completed a word.
- bitcnt  output  clog2(WIDTH)  number of bits held in the partial word, range 0..WIDTH-1.
- parity  output  1  XOR of Qp; present only with the optional feature, else tied 0.

Behaviour:
- Internal state:
  - sr[WIDTH-1:0]: shift register.
  - cnt: bit counter, driven out as bitcnt.
  - Qp and valid registers.
- Reset:
  - Applies on a rising edge of c with rst=1: sr=0, cnt=0, Qp=0, valid=0, parity=0.
  - rst has priority over en.
  - Asserting rst mid-word discards the partial word; Qp is still cleared.
- Shift, on a rising edge with rst=0 and en=1:
  - sr <= {sr[WIDTH-2:0], d}, MSB-first: the first bit received ends up in Qp[WIDTH-1].
  - If cnt < WIDTH-1: cnt <= cnt+1, valid <= 0.
  - If cnt == WIDTH-1 (word completes): Qp <= {sr[WIDTH-2:0], d}, valid <= 1, cnt <= 0 (wrap).
  - sr need not be cleared on completion; the next word overwrites it fully.
- Hold, on a rising edge with rst=0 and en=0:
  - sr, cnt and Qp hold; valid <= 0.
- valid is never high for two consecutive cycles. Back-to-back words with en held high give valid every WIDTH cycles.
- Latency:
  - The last bit of a word is sampled at edge N.
  - Qp and valid update at edge N, so they are visible for the cycle after edge N.
- Qp is stable between completions, and readers may sample it at any time.
- d and en must be stable around the rising edge of c. Changes while c is steady have no effect.
- Initial (pre-reset) state is 0 for all registers, which keeps simulation deterministic.
- Combinational paths from d or en to outputs: none. All outputs are registered.

Optional Feature:
- Macro: SIPO_PARITY_EN.
- Defined:
  - parity is a register loaded with the XOR reduction of the new word on the completing edge, in the same cycle as Qp.
  - parity holds with Qp and clears on reset.
- Undefined:
  - No parity register is built; parity is driven constant 0.
  - All other behaviour is identical.

Test Plan (WIDTH=4):
- Reset: rst=1 for one edge, with en=1 and d=1 -> Qp=0000, valid=0, bitcnt=0, parity=0.
- Single word: en=1, d sequence 1,0,1,1 on four edges -> bitcnt steps 1,2,3,0; after edge 4, Qp=1011 and valid=1 for one cycle; parity=1 when SIPO_PARITY_EN is defined.
- Gaps: en=1 with d=1, then en=0 for 3 edges with d toggling, then en=1 with d=0,0,1 -> no capture while en=0; Qp=1001 after the fourth enabled edge, valid=1 once.
- Back-to-back: en=1 for 8 edges, d=0,1,1,0,1,1,1,1 -> valid after edges 4 and 8 only; Qp=0110, then 1111 (parity 0, then 0).
- Reset mid-word: bits 1,1 shifted, then rst=1 on the third edge, then 0,0,0,1 -> partial word discarded; Qp=0000 after reset, then 0001 with valid=1 after the fourth post-reset edge.
- Wrap: 3 full words with en=1 constantly -> bitcnt never exceeds 3; it returns to 0 on every completion.
